// File: rtl/nibbler_bus_arbiter.sv
// Registered round-robin arbiter for the shared 4-bit Nibbler data bus.
// Grants one requester at a time and drives active-low output enables.
// A one-cycle turnaround separates owners so that bus drivers never overlap.
// A hold timeout recovers the bus from an owner that never releases it.
module nibbler_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         lock,
    input  logic                       clr_err,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         notOe,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [$clog2(NUM_REQ)-1:0] err_id
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  winner;
    logic              release_now;
    logic              timeout_now;

    // Index increment with an explicit wrap, so non-power-of-2 counts work.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    // First requester at or above ptr, wrapping around modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                     input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        idx   = ptr;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return win;
    endfunction

    // Arbitration winner plus release/timeout decisions for the current owner.
    always_comb begin
        winner      = pick_winner(req, rr_ptr);
        release_now = !req[owner] && !lock[owner];
        timeout_now = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && !release_now;
    end

    // Enables are the inverse of the registered grant, so they are glitch-free too.
    assign notOe = ~gnt;

    // Arbiter FSM with registered grant, owner, busy and error outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            err_id      <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (clr_err) begin
                        timeout_err <= 1'b0;
                        err_id      <= '0;
                    end
                    if (|req) begin
                        state    <= GRANT;
                        gnt      <= ONE_HOT0 << winner;
                        owner    <= winner;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now || timeout_now) begin
                        state  <= TURN;
                        gnt    <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_idx(owner);
                    end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    // A new timeout takes precedence over a simultaneous clear.
                    if (timeout_now) begin
                        timeout_err <= 1'b1;
                        err_id      <= owner;
                    end else if (clr_err) begin
                        timeout_err <= 1'b0;
                        err_id      <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
